// File: rtl/ludiv_mem_arbiter.sv
// ludiv_mem_arbiter: shares one memory port between instruction fetch and load/store.
// Registered IDLE/ISSUE/WAIT/DONE request FSM with a starvation guard and a response timeout.
module ludiv_mem_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 16
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_IReq,
  input  logic [63:0] i_IAddr,
  output logic        o_IAck,
  output logic [31:0] o_IRdata,
  input  logic        i_DReq,
  input  logic        i_DWe,
  input  logic [63:0] i_DAddr,
  input  logic [63:0] i_DWdata,
  input  logic [7:0]  i_DWstrb,
  output logic        o_DAck,
  output logic [63:0] o_DRdata,
  output logic        o_Err,
  output logic        o_MReq,
  output logic        o_MWe,
  output logic [63:0] o_MAddr,
  output logic [63:0] o_MWdata,
  output logic [7:0]  o_MWstrb,
  input  logic        i_MGnt,
  input  logic        i_MRvalid,
  input  logic [63:0] i_MRdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TMO_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic          own_d, own_d_n;
  logic          hi, hi_n;
  logic [SW-1:0] starve, starve_n;
  logic [TW-1:0] tmo, tmo_n;

  logic        mreq_n, mwe_n;
  logic [63:0] maddr_n, mwdata_n;
  logic [7:0]  mwstrb_n;
  logic        iack_n, dack_n, err_n;
  logic [31:0] irdata_n;
  logic [63:0] drdata_n;

  logic        pick_d;
  logic [63:0] rsp;
  logic        unused_addr;

  // Low address bits never reach the doubleword-aligned memory port.
  assign unused_addr = ^{i_IAddr[1:0], i_DAddr[2:0]};

  // Data wins a tie unless fetch has been passed over too often.
  assign pick_d = i_DReq && (!i_IReq || (starve < STARVE_MAX));

  // A timed-out read completes with zero data.
  assign rsp = i_MRvalid ? i_MRdata : 64'd0;

  // State register.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_n  = state;
    own_d_n  = own_d;
    hi_n     = hi;
    starve_n = starve;
    tmo_n    = tmo;
    mreq_n   = 1'b0;
    mwe_n    = o_MWe;
    maddr_n  = o_MAddr;
    mwdata_n = o_MWdata;
    mwstrb_n = o_MWstrb;
    iack_n   = 1'b0;
    dack_n   = 1'b0;
    err_n    = 1'b0;
    irdata_n = o_IRdata;
    drdata_n = o_DRdata;
    unique case (state)
      S_IDLE: begin
        if (i_IReq || i_DReq) begin
          state_n = S_ISSUE;
          mreq_n  = 1'b1;
          tmo_n   = '0;
          if (pick_d) begin
            own_d_n  = 1'b1;
            mwe_n    = i_DWe;
            maddr_n  = {i_DAddr[63:3], 3'b000};
            mwdata_n = i_DWdata;
            mwstrb_n = i_DWe ? i_DWstrb : 8'h00;
            if (i_IReq && (starve < STARVE_MAX)) begin
              starve_n = starve + 1'b1;
            end
          end else begin
            own_d_n  = 1'b0;
            hi_n     = i_IAddr[2];
            mwe_n    = 1'b0;
            maddr_n  = {i_IAddr[63:3], 3'b000};
            mwdata_n = 64'd0;
            mwstrb_n = 8'h00;
            starve_n = '0;
          end
        end
      end
      S_ISSUE: begin
        if (i_MGnt) begin
          if (own_d && o_MWe) begin
            state_n = S_DONE;
            dack_n  = 1'b1;
          end else begin
            state_n = S_WAIT;
          end
        end else begin
          mreq_n = 1'b1;
        end
      end
      S_WAIT: begin
        if (i_MRvalid || (TMO_EN && (tmo == TMO_LAST))) begin
          state_n = S_DONE;
          err_n   = !i_MRvalid;
          if (own_d) begin
            dack_n   = 1'b1;
            drdata_n = rsp;
          end else begin
            iack_n   = 1'b1;
            irdata_n = hi ? rsp[63:32] : rsp[31:0];
          end
        end else begin
          tmo_n = tmo + 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Output, transaction and counter registers.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      own_d    <= 1'b0;
      hi       <= 1'b0;
      starve   <= '0;
      tmo      <= '0;
      o_MReq   <= 1'b0;
      o_MWe    <= 1'b0;
      o_MAddr  <= 64'd0;
      o_MWdata <= 64'd0;
      o_MWstrb <= 8'h00;
      o_IAck   <= 1'b0;
      o_DAck   <= 1'b0;
      o_Err    <= 1'b0;
      o_IRdata <= 32'd0;
      o_DRdata <= 64'd0;
    end else begin
      own_d    <= own_d_n;
      hi       <= hi_n;
      starve   <= starve_n;
      tmo      <= tmo_n;
      o_MReq   <= mreq_n;
      o_MWe    <= mwe_n;
      o_MAddr  <= maddr_n;
      o_MWdata <= mwdata_n;
      o_MWstrb <= mwstrb_n;
      o_IAck   <= iack_n;
      o_DAck   <= dack_n;
      o_Err    <= err_n;
      o_IRdata <= irdata_n;
      o_DRdata <= drdata_n;
    end
  end

endmodule
